// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return DATA_W - 2 - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage: one write port, asynchronous read at the same index.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [index_w(LINES)-1:0] index,
  input  logic                      we,
  input  logic [tag_w(LINES)-1:0]   wr_tag,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      rd_valid,
  output logic [tag_w(LINES)-1:0]   rd_tag,
  output logic [DATA_W-1:0]         rd_data
);

  logic [LINES-1:0]         valid;
  logic [tag_w(LINES)-1:0]  tags  [LINES];
  logic [DATA_W-1:0]        data  [LINES];

  // valid bits are the only storage that needs clearing
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= {LINES{1'b0}};
    end else if (we) begin
      valid[index] <= 1'b1;
    end
  end

  // tag and data payload
  always_ff @(posedge clock) begin
    if (we) begin
      tags[index] <= wr_tag;
      data[index] <= wr_data;
    end
  end

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_data  = data[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with a blocking handshake.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memReadFlag,
  input  logic              memWriteFlag,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck
`ifdef DCACHE_STATS_EN
  ,
  output logic [DATA_W-1:0] hitCount,
  output logic [DATA_W-1:0] missCount
`endif
);

  localparam int IW = index_w(LINES);
  localparam int TW = tag_w(LINES);

  state_t            state;
  state_t            state_next;
  logic              done;
  logic [IW-1:0]     index;
  logic [TW-1:0]     tag;
  logic              line_valid;
  logic [TW-1:0]     line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              arr_we;
  logic [DATA_W-1:0] arr_data;
  logic              unused_low;

  assign index      = address[IW+1:2];
  assign tag        = address[DATA_W-1:IW+2];
  assign hit        = line_valid && (line_tag == tag);
  assign unused_low = ^address[1:0];

  dcache_array #(.LINES(LINES)) u_array (
    .clock    (clock),
    .reset    (reset),
    .index    (index),
    .we       (arr_we),
    .wr_tag   (tag),
    .wr_data  (arr_data),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  // next state, stall and array write; 'done' marks the IDLE cycle that retires a held request
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    arr_we     = 1'b0;
    arr_data   = writeData;
    case (state)
      IDLE: begin
        if (done) begin
          state_next = IDLE;
        end else if (memWriteFlag) begin
          stall      = 1'b1;
          state_next = WRITE;
          arr_we     = hit;
        end else if (memReadFlag && !hit) begin
          stall      = 1'b1;
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        stall    = 1'b1;
        arr_data = memRdata;
        if (memAck) begin
          arr_we     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (memAck) begin
          state_next = IDLE;
        end else begin
          state_next = WRITE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // state register and registered backing-memory / load outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      readData <= {DATA_W{1'b0}};
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= {DATA_W{1'b0}};
      memWdata <= {DATA_W{1'b0}};
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (!done && memWriteFlag) begin
            memReq   <= 1'b1;
            memWe    <= 1'b1;
            memAddr  <= {address[DATA_W-1:2], 2'b00};
            memWdata <= writeData;
          end else if (!done && memReadFlag) begin
            if (hit) begin
              readData <= line_data;
            end else begin
              memReq  <= 1'b1;
              memWe   <= 1'b0;
              memAddr <= {address[DATA_W-1:2], 2'b00};
            end
          end
        end
        FILL: begin
          if (memAck) begin
            memReq   <= 1'b0;
            readData <= memRdata;
            done     <= 1'b1;
          end
        end
        WRITE: begin
          if (memAck) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          memReq <= 1'b0;
          memWe  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // saturating hit/miss counters, one step per accepted read
  always_ff @(posedge clock) begin
    if (reset) begin
      hitCount  <= {DATA_W{1'b0}};
      missCount <= {DATA_W{1'b0}};
    end else if (state == IDLE && !done && memReadFlag && !memWriteFlag) begin
      if (hit) begin
        if (hitCount != {DATA_W{1'b1}}) hitCount <= hitCount + 32'd1;
      end else begin
        if (missCount != {DATA_W{1'b1}}) missCount <= missCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 Port: clock  in  1  main clock; sole clock, all state updates on its rising edge.
REQ-003 Port: reset  in  1  reset; synchronous and active-high.
REQ-004 Port: address  in  32  byte address from the ALU result; bits [1:0] ignored.
REQ-005 Port: writeData  in  32  store data.
REQ-006 Port: memReadFlag  in  1  load request from Decoder & Control.
REQ-007 Port: memWriteFlag  in  1  store request from Decoder & Control.
REQ-008 Port: readData  out  32  registered load result.
REQ-009 Port: stall  out  1  combinational; high means the pipeline holds all inputs stable.
REQ-010 Port: memReq / memWe  out  1 / 1  backing-memory request and write strobe.
REQ-011 Port: memAddr / memWdata  out  32 / 32  backing-memory word address (bits [1:0] = 0) and write data.
REQ-012 Port: memRdata / memAck  in  32 / 1  backing-memory read data, valid in the cycle memAck = 1.

Function
REQ-013 Index = address[log2(LINES)+1:2]; tag = address[31:log2(LINES)+2]; hit = valid[index] and tag match.
REQ-014 FSM states: IDLE, FILL, WRITE; the block accepts a request only in IDLE.
REQ-015 IDLE read hit: stall = 0; at the next edge readData <= line data; state remains IDLE (1-cycle latency).
REQ-016 IDLE read miss: stall = 1 in the same cycle; next state FILL.
REQ-017 FILL: memReq = 1, memWe = 0, memAddr = {address[31:2],2'b00}; on memAck, line <= memRdata, tag written, valid set, readData <= memRdata, next state IDLE.
REQ-018 IDLE write: stall = 1; next state WRITE; on a hit the line data updates at that edge (write-through, no write-allocate).
REQ-019 WRITE: memReq = 1, memWe = 1, memWdata = writeData; on memAck, next state IDLE; a write miss leaves the cache contents unchanged.
REQ-020 stall = 1 in all FILL and WRITE cycles, including the memAck cycle; it drops in the first IDLE cycle.
REQ-021 memReq holds high and memAddr/memWdata hold stable until memAck; memAck in IDLE is ignored.
REQ-022 memReadFlag and memWriteFlag both high: the request is treated as a write only.
REQ-023 Neither flag set: no state change; readData holds its value.
REQ-024 A read that follows a write to the same address observes the written data.

Reset
REQ-025 Reset: state = IDLE, all valid bits = 0, readData = 0, memReq = 0, memWe = 0, memAddr = 0, memWdata = 0; line data and tags need not be reset.
REQ-026 Reset asserted during FILL or WRITE aborts the transaction; memReq is low in the cycle after reset; a late memAck writes nothing.

Configuration
REQ-027 Macro DCACHE_STATS_EN defined: outputs hitCount[31:0] and missCount[31:0] are added; each increments once per read request accepted in IDLE; both reset to 0 and saturate at 0xFFFFFFFF.
REQ-028 Macro DCACHE_STATS_EN undefined: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-029 Shared package dcache_pkg holds the FSM state enum typedef, the DATA_W = 32 constant and the tag/index width functions.
REQ-030 Sub-module dcache_array (tag, valid and data storage; 1 write port, asynchronous read) is instantiated once; the FSM and the handshake stay in data_cache.

Verification
REQ-031 Reset, then read 0x40; memAck after 3 cycles with memRdata = 0xDEADBEEF -> stall high for 4 cycles, readData = 0xDEADBEEF, memAddr = 0x40.
REQ-032 Read 0x40 again -> no memReq, stall = 0, readData = 0xDEADBEEF at the next edge; with DCACHE_STATS_EN, hitCount = 1 and missCount = 1.
REQ-033 Write 0x12345678 to 0x40 (hit), then read 0x40 -> memWe pulse with memWdata = 0x12345678; the read hits and returns 0x12345678.
REQ-034 Read 0x80 with LINES = 16 (same index as 0x40, different tag) -> miss and fill; a subsequent read of 0x40 misses again.
REQ-035 Both flags high at 0x100 -> only a write transaction (memWe = 1) and no fill; a later read of 0x100 misses.
REQ-036 Reset asserted mid-FILL, then memAck driven -> memReq low the cycle after reset, valid bits cleared, and a read of the same address misses.
